// File: rtl/ff_bank_init_pkg.sv
// rtl/ff_bank_init_pkg.sv - shared types and width helpers for the flop-bank init sequencer
package ff_bank_init_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SCAN   = 3'd1,
      ASSERT = 3'd2,
      SETTLE = 3'd3,
      DONE   = 3'd4
   } state_t;

   // Bank index width; a single bank still gets a 1-bit index.
   function automatic int calc_bank_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Down-counter width: holds max(hold, settle) - 1, at least one bit.
   function automatic int calc_cnt_w(input int hold, input int settle);
      int m;
      m = (hold > settle) ? hold : settle;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

   // Widths for the default configuration (4 banks, hold 2, settle 1).
   localparam int DEF_NUM_BANKS  = 4;
   localparam int DEF_HOLD_CYC   = 2;
   localparam int DEF_SETTLE_CYC = 1;
   localparam int DEF_BANK_W     = calc_bank_w(DEF_NUM_BANKS);
   localparam int DEF_CNT_W      = calc_cnt_w(DEF_HOLD_CYC, DEF_SETTLE_CYC);

endpackage

// File: rtl/ff_bank_init_prio_enc.sv
// rtl/ff_bank_init_prio_enc.sv - combinational lowest-set-bit encoder
module ff_bank_init_prio_enc
   import ff_bank_init_pkg::*;
#(
   parameter int N = 4,
   parameter int W = 2
)(
   input  logic [N-1:0] vec,
   output logic [W-1:0] idx,
   output logic         any
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = W'(i);
         end
      end
      any = |vec;
   end

endmodule

// File: rtl/ff_bank_init_seq.sv
// rtl/ff_bank_init_seq.sv - sequences clear/preset pulses onto flop banks one at a time
module ff_bank_init_seq
   import ff_bank_init_pkg::*;
#(
   parameter int NUM_BANKS  = 4,
   parameter int HOLD_CYC   = 2,
   parameter int SETTLE_CYC = 1,
   localparam int BANK_W    = calc_bank_w(NUM_BANKS)
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [NUM_BANKS-1:0] bank_en,
   input  logic [NUM_BANKS-1:0] pre_sel,
   input  logic                 abort,
   output logic [NUM_BANKS-1:0] clr_o,
   output logic [NUM_BANKS-1:0] pre_o,
   output logic [BANK_W-1:0]    cur_bank,
   output logic                 busy,
   output logic                 done,
   output logic                 aborted
);

   localparam int CNT_W = calc_cnt_w(HOLD_CYC, SETTLE_CYC);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

   state_t               state, state_nx;
   logic [CNT_W-1:0]     cnt, cnt_nx;
   logic [NUM_BANKS-1:0] en_sh, en_sh_nx;
   logic [NUM_BANKS-1:0] pre_sh, pre_sh_nx;
   logic [BANK_W-1:0]    cur_bank_nx;
   logic [NUM_BANKS-1:0] clr_nx, pre_nx;
   logic                 busy_nx, done_nx, aborted_nx;
   logic [BANK_W-1:0]    enc_idx;
   logic                 enc_any;

   ff_bank_init_prio_enc #(
      .N (NUM_BANKS),
      .W (BANK_W)
   ) u_prio_enc (
      .vec (en_sh),
      .idx (enc_idx),
      .any (enc_any)
   );

   // Next-state logic; output vectors default to all-low so only one bit is ever set.
   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      en_sh_nx    = en_sh;
      pre_sh_nx   = pre_sh;
      cur_bank_nx = cur_bank;
      clr_nx      = '0;
      pre_nx      = '0;
      aborted_nx  = 1'b0;

      case (state)
         IDLE: begin
            // Abort has no meaning here; start alone decides.
            if (start) begin
               en_sh_nx  = bank_en;
               pre_sh_nx = pre_sel;
               state_nx  = SCAN;
            end
         end

         SCAN: begin
            if (abort) begin
               en_sh_nx   = '0;
               pre_sh_nx  = '0;
               aborted_nx = 1'b1;
               state_nx   = DONE;
            end else if (enc_any) begin
               cur_bank_nx = enc_idx;
               cnt_nx      = HOLD_LAST;
               state_nx    = ASSERT;
               if (pre_sh[enc_idx]) begin
                  pre_nx[enc_idx] = 1'b1;
               end else begin
                  clr_nx[enc_idx] = 1'b1;
               end
            end else begin
               state_nx = DONE;
            end
         end

         ASSERT: begin
            if (abort) begin
               en_sh_nx   = '0;
               pre_sh_nx  = '0;
               aborted_nx = 1'b1;
               state_nx   = DONE;
            end else if (cnt == '0) begin
               cnt_nx   = SETTLE_LAST;
               state_nx = SETTLE;
            end else begin
               cnt_nx = cnt - 1'b1;
               if (pre_sh[cur_bank]) begin
                  pre_nx[cur_bank] = 1'b1;
               end else begin
                  clr_nx[cur_bank] = 1'b1;
               end
            end
         end

         SETTLE: begin
            if (abort) begin
               en_sh_nx   = '0;
               pre_sh_nx  = '0;
               aborted_nx = 1'b1;
               state_nx   = DONE;
            end else if (cnt == '0) begin
               // Retire this bank so the encoder moves on to the next one.
               en_sh_nx[cur_bank] = 1'b0;
               state_nx           = SCAN;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end

         DONE: begin
            state_nx = IDLE;
         end

         default: begin
            state_nx  = IDLE;
            en_sh_nx  = '0;
            pre_sh_nx = '0;
         end
      endcase

      busy_nx = (state_nx == SCAN) || (state_nx == ASSERT) || (state_nx == SETTLE);
      done_nx = (state_nx == DONE);
   end

   // State, shadow masks and counter; reset drops everything at once, even mid-pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         en_sh    <= '0;
         pre_sh   <= '0;
         cur_bank <= '0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         en_sh    <= en_sh_nx;
         pre_sh   <= pre_sh_nx;
         cur_bank <= cur_bank_nx;
      end
   end

   // Registered outputs so the clr/pre pins never see combinational glitches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_o   <= '0;
         pre_o   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         aborted <= 1'b0;
      end else begin
         clr_o   <= clr_nx;
         pre_o   <= pre_nx;
         busy    <= busy_nx;
         done    <= done_nx;
         aborted <= aborted_nx;
      end
   end

endmodule

// File: tb/tb_ff_bank_init_seq.sv
// tb/tb_ff_bank_init_seq.sv - self-checking bench for ff_bank_init_seq
module tb_ff_bank_init_seq;

   localparam int NB = 4;
   localparam int H  = 2;
   localparam int S  = 1;
   localparam int P  = H + S + 1;
   localparam int BW = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [NB-1:0] bank_en = '0;
   logic [NB-1:0] pre_sel = '0;
   logic [NB-1:0] clr_o, pre_o;
   logic [BW-1:0] cur_bank;
   logic          busy, done, aborted;

   ff_bank_init_seq #(
      .NUM_BANKS  (NB),
      .HOLD_CYC   (H),
      .SETTLE_CYC (S)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .bank_en  (bank_en),
      .pre_sel  (pre_sel),
      .abort    (abort),
      .clr_o    (clr_o),
      .pre_o    (pre_o),
      .cur_bank (cur_bank),
      .busy     (busy),
      .done     (done),
      .aborted  (aborted)
   );

   always #5 clk = ~clk;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;

   // Reference model: a sequence is described by its start cycle, its bank list and an optional abort cycle.
   bit            has_seq = 1'b0;
   int            s_c = 0;
   int            ab_c = -1;
   int            banks[$];
   logic [NB-1:0] m_pre = '0;
   logic [BW-1:0] prev_cur = '0;
   logic [NB-1:0] e_clr, e_pre;
   logic          e_busy, e_done, e_ab;
   logic [BW-1:0] e_cur = '0;

   function automatic int seq_end_r();
      if (ab_c >= 0) return ab_c - s_c + 1;
      return 2 + banks.size() * P;
   endfunction

   function automatic bit model_idle(input int c);
      return !has_seq || ((c - s_c) > seq_end_r());
   endfunction

   function automatic bit model_busy(input int c);
      int r;
      r = c - s_c;
      return has_seq && (r >= 1) && (r < seq_end_r());
   endfunction

   task automatic model_eval(input int c);
      int r, endr, k, o, b;
      e_clr  = '0;
      e_pre  = '0;
      e_busy = 1'b0;
      e_done = 1'b0;
      e_ab   = 1'b0;
      e_cur  = prev_cur;
      if (has_seq) begin
         r    = c - s_c;
         endr = seq_end_r();
         e_busy = (r >= 1) && (r < endr);
         e_done = (r == endr);
         e_ab   = e_done && (ab_c >= 0);
         for (int i = 0; i < banks.size(); i++) begin
            if ((2 + i * P <= r) && (2 + i * P < endr)) e_cur = BW'(banks[i]);
         end
         if ((r >= 2) && (r < endr)) begin
            k = (r - 2) / P;
            o = (r - 2) % P;
            if ((k < banks.size()) && (o < H)) begin
               b = banks[k];
               if (m_pre[b]) e_pre[b] = 1'b1;
               else          e_clr[b] = 1'b1;
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      has_seq  = 1'b0;
      ab_c     = -1;
      banks.delete();
      prev_cur = '0;
      e_cur    = '0;
   endtask

   // Drive one cycle of inputs, let the edge pass, then compare every output against the model.
   task automatic run_cycle(input logic st, input logic ab, input logic [NB-1:0] en, input logic [NB-1:0] ps);
      start   = st;
      abort   = ab;
      bank_en = en;
      pre_sel = ps;
      if (st && model_idle(cyc)) begin
         prev_cur = e_cur;
         has_seq  = 1'b1;
         s_c      = cyc;
         ab_c     = -1;
         banks.delete();
         for (int i = 0; i < NB; i++) if (en[i]) banks.push_back(i);
         m_pre = ps;
      end else if (ab && model_busy(cyc) && (ab_c < 0)) begin
         ab_c = cyc;
      end
      @(posedge clk);
      #1;
      cyc++;
      model_eval(cyc);
      chk("clr_o", 32'(clr_o), 32'(e_clr));
      chk("pre_o", 32'(pre_o), 32'(e_pre));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("aborted", 32'(aborted), 32'(e_ab));
      chk("cur_bank", 32'(cur_bank), 32'(e_cur));
      chk("onehot", 32'($onehot0(clr_o | pre_o)), 32'd1);
      chk("exclusive", 32'(clr_o & pre_o), 32'd0);
   endtask

   initial begin
      int t, r, done_cnt;
      logic [NB-1:0] touched;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_clr", 32'(clr_o), 32'd0);
      chk("rst_pre", 32'(pre_o), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_cur", 32'(cur_bank), 32'd0);
      rst_n = 1'b1;
      model_reset();
      run_cycle(1'b0, 1'b0, '0, '0);

      // 1: banks 0 (clear) and 2 (preset), fixed timeline
      t = cyc;
      run_cycle(1'b1, 1'b0, 4'b0101, 4'b0100);
      for (int i = 0; i < 12; i++) begin
         r = cyc - t;
         chk("t1_clr0", 32'(clr_o[0]), 32'((r == 2) || (r == 3)));
         chk("t1_pre2", 32'(pre_o[2]), 32'((r == 6) || (r == 7)));
         chk("t1_done", 32'(done), 32'(r == 10));
         chk("t1_busy", 32'(busy), 32'((r >= 1) && (r <= 9)));
         run_cycle(1'b0, 1'b0, NB'($urandom), NB'($urandom));
      end

      // 2: empty bank mask
      t = cyc;
      run_cycle(1'b1, 1'b0, 4'b0000, NB'($urandom));
      for (int i = 0; i < 3; i++) begin
         r = cyc - t;
         chk("t2_done", 32'(done), 32'(r == 2));
         chk("t2_pins", 32'(clr_o | pre_o), 32'd0);
         chk("t2_aborted", 32'(aborted), 32'd0);
         run_cycle(1'b0, 1'b0, '0, '0);
      end

      // 3: abort during the first bank's pulse
      t = cyc;
      touched = '0;
      run_cycle(1'b1, 1'b0, 4'b1111, 4'b0000);
      run_cycle(1'b0, 1'b0, 4'b1111, 4'b0000);
      run_cycle(1'b0, 1'b0, 4'b1111, 4'b0000);
      run_cycle(1'b0, 1'b1, 4'b1111, 4'b0000);
      chk("t3_at", 32'(cyc - t), 32'd4);
      chk("t3_pins", 32'(clr_o | pre_o), 32'd0);
      chk("t3_done", 32'(done), 32'd1);
      chk("t3_aborted", 32'(aborted), 32'd1);
      for (int i = 0; i < 6; i++) begin
         run_cycle(1'b0, 1'b0, 4'b1111, 4'b0000);
         touched |= clr_o | pre_o;
      end
      chk("t3_untouched", 32'(touched[3:1]), 32'd0);

      // 4: start re-pulsed while running is ignored
      t = cyc;
      done_cnt = 0;
      run_cycle(1'b1, 1'b0, 4'b1111, 4'b1010);
      for (int i = 0; i < 24; i++) begin
         r = cyc - t;
         run_cycle(r == 5, 1'b0, 4'b1111, 4'b0101);
         if (done) done_cnt++;
      end
      chk("t4_done_count", 32'(done_cnt), 32'd1);

      // 5: asynchronous reset in the middle of a clear pulse
      t = cyc;
      run_cycle(1'b1, 1'b0, 4'b0001, 4'b0000);
      run_cycle(1'b0, 1'b0, 4'b0001, 4'b0000);
      chk("t5_pre_rst_clr", 32'(clr_o[0]), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t5_async_clr", 32'(clr_o), 32'd0);
      chk("t5_async_busy", 32'(busy), 32'd0);
      chk("t5_async_cur", 32'(cur_bank), 32'd0);
      @(posedge clk);
      #1;
      cyc++;
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b0, 4'b1111, 4'b1111);
      chk("t5_idle_busy", 32'(busy), 32'd0);

      // 6: random traffic with random aborts and mask changes
      for (int i = 0; i < 10000; i++) begin
         run_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0,
                   NB'($urandom), NB'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
